// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed little-endian program over a byte stream,
// writes it word by word into instruction memory, then releases the CPU from reset.
module prog_loader #(
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [11:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [11:0]   count_q, count_d;
    logic [11:0]   widx_q, widx_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [31:0]   word_q, word_d;
    logic [11:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          accept;

    assign in_ready   = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign accept     = in_valid && in_ready;
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                state_d = HDR0;
                tmo_d   = '0;
            end
            HDR0: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    tmo_d        = '0;
                    state_d      = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d[11:8] = in_data[3:0];
                    tmo_d         = '0;
                    widx_d        = '0;
                    bidx_d        = '0;
                    state_d       = ({in_data[3:0], count_q[7:0]} == 12'd0) ? DONE : DATA;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    // Shift in from the top: after four bytes, byte 0 sits in [7:0].
                    word_d = {in_data, word_q[31:8]};
                    bidx_d = bidx_q + 2'd1;
                    tmo_d  = '0;
                    if (bidx_q == 2'd3) begin
                        addr_d  = widx_q;
                        wdata_d = {in_data, word_q[31:8]};
                        state_d = WRITE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WRITE: begin
                if (widx_q == count_q - 12'd1) begin
                    state_d = DONE;
                end else begin
                    widx_d  = widx_q + 12'd1;
                    bidx_d  = '0;
                    state_d = DATA;
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    tmo_d   = '0;
                    state_d = HDR0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes, a negedge monitor
// pops and compares every imem_we pulse and checks address/data hold between writes.
module tb_prog_loader;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         expq[$];
    wr_t         e;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] hold_a = '0;
    logic [31:0] hold_d = '0;
    logic [11:0] wa;

    prog_loader #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected writes, verify hold values on all other cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_a = '0;
                hold_d = '0;
            end
            if (imem_we) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h at %0t", imem_addr, imem_wdata, $time);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", {20'd0, imem_addr}, {20'd0, e.a});
                    chk("wr_data", imem_wdata, e.d);
                    hold_a = e.a;
                    hold_d = e.d;
                end
                chk("ready_in_write", {31'd0, in_ready}, 32'd0);
            end else begin
                chk("hold_addr", {20'd0, imem_addr}, {20'd0, hold_a});
                chk("hold_data", imem_wdata, hold_d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: in_ready %b expected 1 within 200 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] a, input logic [31:0] d, input bit gaps);
        expq.push_back({a, d});
        for (int k = 0; k < 4; k++)
            send_byte(d[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_ready", {31'd0, in_ready}, 32'd1);
        chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("reload_done", {31'd0, done}, 32'd0);
        chk("reload_error", {31'd0, error}, 32'd0);
    endtask

    task automatic basic_load();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        chk("load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        send_word(12'd0, 32'h00200013, 1'b0);
        send_word(12'd1, 32'h12345678, 1'b0);
        chk("last_write_we", {31'd0, imem_we}, 32'd1);
        @(negedge clk);
        chk("basic_done", {31'd0, done}, 32'd1);
        chk("basic_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("basic_error", {31'd0, error}, 32'd0);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_addr", {20'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("hdr0_after_release", {31'd0, in_ready}, 32'd1);

        basic_load();

        // empty program
        do_reload();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        // back-pressure / gaps
        do_reload();
        send_byte(8'h02, 2);
        send_byte(8'h00, 3);
        send_word(12'd0, 32'h00200013, 1'b1);
        send_word(12'd1, 32'h12345678, 1'b1);
        @(negedge clk);
        chk("gaps_done", {31'd0, done}, 32'd1);
        chk("gaps_queue_empty", expq.size(), 32'd0);

        // timeout
        do_reload();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(12'd0, 32'hDEADBEEF, 1'b0);
        send_byte(8'h11, 0);
        repeat (TO - 1) @(negedge clk);
        chk("tmo_not_yet", {31'd0, error}, 32'd0);
        @(negedge clk);
        chk("tmo_error", {31'd0, error}, 32'd1);
        chk("tmo_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("tmo_done", {31'd0, done}, 32'd0);
        chk("tmo_ready", {31'd0, in_ready}, 32'd0);
        chk("tmo_one_write", expq.size(), 32'd0);
        do_reload();

        // reset mid-word
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_error", {31'd0, error}, 32'd0);
        chk("mid_rst_addr", {20'd0, imem_addr}, 32'd0);
        chk("mid_rst_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_hdr0", {31'd0, in_ready}, 32'd1);
        basic_load();

        // maximum load; upper nibble of second header byte ignored
        do_reload();
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        for (int w = 0; w < 4095; w++) begin
            wa = w[11:0];
            send_word(wa, {8'h5A, 8'hA5, 4'h0, wa[11:8], wa[7:0]}, 1'b0);
        end
        @(negedge clk);
        chk("max_done", {31'd0, done}, 32'd1);
        chk("max_last_addr", {20'd0, imem_addr}, 32'd4094);
        chk("max_last_data", imem_wdata, 32'h5AA50FFE);
        chk("final_queue_empty", expq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
